// File: rtl/banco_registradores_param_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_pkg : shared defaults, types and helpers for the register file
// Rev 1.0
// ----------------------------------------------------------------------------
package banco_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;

  // Callers zero-extend their address to 32 bits so one helper serves any ADDR_WIDTH.
  function automatic logic is_zero_addr(input logic [31:0] addr);
    return (addr == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/banco_registradores_param_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_registradores_param_if : write, read and reserve bus of the register file
// Rev 1.0
// ----------------------------------------------------------------------------
interface banco_registradores_param_if
  import banco_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_READ   = 2
);
  logic                           regWrite_0;
  logic [ADDR_WIDTH-1:0]          write_register_0;
  logic [DATA_WIDTH-1:0]          write_data_0;
  logic                           regWrite_1;
  logic [ADDR_WIDTH-1:0]          write_register_1;
  logic [DATA_WIDTH-1:0]          write_data_1;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_register;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic                           reserve_en;
  logic [ADDR_WIDTH-1:0]          reserve_register;
  logic [NUM_READ-1:0]            read_pending;
  logic                           any_pending;

  modport master (
    output regWrite_0, write_register_0, write_data_0,
    output regWrite_1, write_register_1, write_data_1,
    output read_register, reserve_en, reserve_register,
    input  read_data, read_pending, any_pending
  );

  modport slave (
    input  regWrite_0, write_register_0, write_data_0,
    input  regWrite_1, write_register_1, write_data_1,
    input  read_register, reserve_en, reserve_register,
    output read_data, read_pending, any_pending
  );
endinterface
`default_nettype wire

// File: rtl/banco_registradores_param_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_scoreboard : per-register pending bits set on reserve, cleared on write
// Rev 1.0
// ----------------------------------------------------------------------------
module banco_scoreboard
  import banco_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  wire logic                           clock,
  input  wire logic                           reset,
  input  wire logic                           we0_i,
  input  wire logic [ADDR_WIDTH-1:0]          wa0_i,
  input  wire logic                           we1_i,
  input  wire logic [ADDR_WIDTH-1:0]          wa1_i,
  input  wire logic                           reserve_en_i,
  input  wire logic [ADDR_WIDTH-1:0]          reserve_addr_i,
  input  wire logic [NUM_READ*ADDR_WIDTH-1:0] read_addr_i,
  output logic      [NUM_READ-1:0]            read_pending_o,
  output logic                                any_pending_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Set comes after the clears so a new producer issued alongside a writeback stays pending.
  always_comb begin
    pending_d = pending_q;
    if (we0_i) pending_d[wa0_i] = 1'b0;
    if (we1_i) pending_d[wa1_i] = 1'b0;
    if (reserve_en_i) pending_d[reserve_addr_i] = 1'b1;
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_pend
    assign read_pending_o[k] = pending_q[read_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
  end

  assign any_pending_o = |pending_q;
endmodule
`default_nettype wire

// File: rtl/banco_registradores_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banco_registradores_param : clocked dual-write, multi-read register file
// Rev 1.0
// ----------------------------------------------------------------------------
module banco_registradores_param
  import banco_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input wire logic                     clock,
  input wire logic                     reset,
  banco_registradores_param_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  drop0;
  logic                  drop1;

  assign drop0 = (ZERO_REG != 0) && is_zero_addr(32'(bus.write_register_0));
  assign drop1 = (ZERO_REG != 0) && is_zero_addr(32'(bus.write_register_1));

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (bus.regWrite_0 && !drop0) regs_q[bus.write_register_0] <= bus.write_data_0;
      if (bus.regWrite_1 && !drop1) regs_q[bus.write_register_1] <= bus.write_data_1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = bus.read_register[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = regs_q[addr];
      if (BYPASS != 0) begin
        if (bus.regWrite_1 && bus.write_register_1 == addr)      data = bus.write_data_1;
        else if (bus.regWrite_0 && bus.write_register_0 == addr) data = bus.write_data_0;
      end
      if (reset || ((ZERO_REG != 0) && is_zero_addr(32'(addr)))) data = '0;
    end

    assign bus.read_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
  end

  banco_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .we0_i          (bus.regWrite_0),
    .wa0_i          (bus.write_register_0),
    .we1_i          (bus.regWrite_1),
    .wa1_i          (bus.write_register_1),
    .reserve_en_i   (bus.reserve_en),
    .reserve_addr_i (bus.reserve_register),
    .read_addr_i    (bus.read_register),
    .read_pending_o (bus.read_pending),
    .any_pending_o  (bus.any_pending)
  );
endmodule
`default_nettype wire

// File: tb/tb_banco_registradores_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_banco_registradores_param : scoreboard bench, bypass/zero-reg DUT and plain DUT
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_banco_registradores_param;
  import banco_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  banco_registradores_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) bus_a ();
  banco_registradores_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus_b ();

  banco_registradores_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  banco_registradores_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  int          n_vec = 0;
  int          n_err = 0;
  reg_data_t   mdl_a [32];
  reg_data_t   mdl_b [32];
  logic [31:0] pnd_a;
  logic [31:0] pnd_b;
  logic [63:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic reg_data_t fwd_a(input reg_addr_t a);
    if (a == 5'd0) return '0;
    if (bus_a.regWrite_1 && bus_a.write_register_1 == a) return bus_a.write_data_1;
    if (bus_a.regWrite_0 && bus_a.write_register_0 == a) return bus_a.write_data_0;
    return mdl_a[a];
  endfunction

  task automatic push(input string tag, input logic [63:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic expect_all();
    reg_addr_t a;
    for (int k = 0; k < 4; k++) begin
      a = bus_a.read_register[k*5 +: 5];
      push($sformatf("a_rd%0d", k), 64'(fwd_a(a)));
      push($sformatf("a_pend%0d", k), 64'(pnd_a[a]));
    end
    push("a_any", 64'(|pnd_a));
    for (int k = 0; k < 2; k++) begin
      a = bus_b.read_register[k*5 +: 5];
      push($sformatf("b_rd%0d", k), 64'(mdl_b[a]));
      push($sformatf("b_pend%0d", k), 64'(pnd_b[a]));
    end
    push("b_any", 64'(|pnd_b));
  endtask

  task automatic drain();
    logic [63:0] obs [$];
    for (int k = 0; k < 4; k++) begin
      obs.push_back(64'(bus_a.read_data[k*32 +: 32]));
      obs.push_back(64'(bus_a.read_pending[k]));
    end
    obs.push_back(64'(bus_a.any_pending));
    for (int k = 0; k < 2; k++) begin
      obs.push_back(64'(bus_b.read_data[k*32 +: 32]));
      obs.push_back(64'(bus_b.read_pending[k]));
    end
    obs.push_back(64'(bus_b.any_pending));
    while (exp_q.size() > 0)
      check(tag_q.pop_front(), obs.pop_front(), exp_q.pop_front());
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    pnd_a = '0;
    pnd_b = '0;
  endtask

  // Models advance to the post-edge state using the inputs held across the edge.
  task automatic commit();
    if (reset) begin
      clear_models();
    end else begin
      if (bus_a.regWrite_0 && bus_a.write_register_0 != 0) mdl_a[bus_a.write_register_0] = bus_a.write_data_0;
      if (bus_a.regWrite_1 && bus_a.write_register_1 != 0) mdl_a[bus_a.write_register_1] = bus_a.write_data_1;
      if (bus_a.regWrite_0) pnd_a[bus_a.write_register_0] = 1'b0;
      if (bus_a.regWrite_1) pnd_a[bus_a.write_register_1] = 1'b0;
      if (bus_a.reserve_en && bus_a.reserve_register != 0) pnd_a[bus_a.reserve_register] = 1'b1;
      if (bus_b.regWrite_0) mdl_b[bus_b.write_register_0] = bus_b.write_data_0;
      if (bus_b.regWrite_1) mdl_b[bus_b.write_register_1] = bus_b.write_data_1;
      if (bus_b.regWrite_0) pnd_b[bus_b.write_register_0] = 1'b0;
      if (bus_b.regWrite_1) pnd_b[bus_b.write_register_1] = 1'b0;
      if (bus_b.reserve_en) pnd_b[bus_b.reserve_register] = 1'b1;
    end
  endtask

  task automatic step();
    expect_all();
    #2;
    drain();
    commit();
    @(negedge clock);
  endtask

  task automatic idle();
    bus_a.regWrite_0 = 0; bus_a.write_register_0 = '0; bus_a.write_data_0 = '0;
    bus_a.regWrite_1 = 0; bus_a.write_register_1 = '0; bus_a.write_data_1 = '0;
    bus_a.reserve_en = 0; bus_a.reserve_register = '0;
    bus_b.regWrite_0 = 0; bus_b.write_register_0 = '0; bus_b.write_data_0 = '0;
    bus_b.regWrite_1 = 0; bus_b.write_register_1 = '0; bus_b.write_data_1 = '0;
    bus_b.reserve_en = 0; bus_b.reserve_register = '0;
  endtask

  // Same write/reserve on both DUTs, every read port pointed at one address.
  task automatic drive(input logic we0, input reg_addr_t wa0, input reg_data_t wd0,
                       input logic we1, input reg_addr_t wa1, input reg_data_t wd1,
                       input logic res, input reg_addr_t ra, input reg_addr_t rd);
    bus_a.regWrite_0 = we0; bus_a.write_register_0 = wa0; bus_a.write_data_0 = wd0;
    bus_a.regWrite_1 = we1; bus_a.write_register_1 = wa1; bus_a.write_data_1 = wd1;
    bus_a.reserve_en = res; bus_a.reserve_register = ra;
    bus_b.regWrite_0 = we0; bus_b.write_register_0 = wa0; bus_b.write_data_0 = wd0;
    bus_b.regWrite_1 = we1; bus_b.write_register_1 = wa1; bus_b.write_data_1 = wd1;
    bus_b.reserve_en = res; bus_b.reserve_register = ra;
    bus_a.read_register = {4{rd}};
    bus_b.read_register = {2{rd}};
  endtask

  initial begin
    clear_models();
    reset = 1'b1;
    idle();
    bus_a.read_register = '0;
    bus_b.read_register = '0;
    @(negedge clock);
    step();
    reset = 1'b0;
    step();

    // Preload reg 5 and reserve reg 9, then assert reset between edges.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 5'd9, 5'd5);
    step();
    idle();
    step();
    drive(1, 5'd5, 32'h00001234, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5);
    #2;
    reset = 1'b1;
    #1;
    check("rst_a_rd5", 64'(bus_a.read_data[31:0]), 64'h0);
    check("rst_a_any", 64'(bus_a.any_pending), 64'h0);
    check("rst_a_pend", 64'(bus_a.read_pending), 64'h0);
    check("rst_b_rd5", 64'(bus_b.read_data[31:0]), 64'h0);
    check("rst_b_any", 64'(bus_b.any_pending), 64'h0);
    @(negedge clock);
    clear_models();
    reset = 1'b0;
    idle();
    step();

    // Write/read reg 8: same-cycle on the bypass DUT, next cycle on the plain DUT.
    drive(1, 5'd8, 32'h00000011, 0, 5'd0, 32'h0, 0, 5'd0, 5'd8);
    step();
    idle();
    step();

    // Dual-port collision on reg 3.
    drive(1, 5'd3, 32'h0000AAAA, 1, 5'd3, 32'h00005555, 0, 5'd0, 5'd3);
    step();
    idle();
    step();

    // Write and reserve reg 0.
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0);
    step();
    idle();
    step();
    drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0);
    step();
    idle();
    step();

    // Scoreboard on reg 12.
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd12, 5'd12);
    step();
    idle();
    step();
    drive(1, 5'd12, 32'h00000040, 0, 5'd0, 32'h0, 0, 5'd0, 5'd12);
    step();
    idle();
    step();
    drive(1, 5'd12, 32'h00000040, 0, 5'd0, 32'h0, 1, 5'd12, 5'd12);
    step();
    idle();
    step();

    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom));
      bus_a.read_register = 20'($urandom);
      bus_b.read_register = 10'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
